pong_game_ctrl: RTL and testbench
=================================

# pong_game_ctrl

Game-flow controller for the two-paddle Pong design. It sits directly downstream of the graphics stage: it consumes the paddle `hit`, `hit2` and `miss` status flags, keeps both players' scores and the rally length, and decides the winner. It drives `gra_still` back into the graphics stage to freeze and centre the ball between points. It also debounces the raw start button.

## Interface
- `WIN_SCORE`, default 9: score that ends the game; range 1..15.
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable synchronized samples required to accept a start-button change.
- `SERVE_DELAY_CYCLES`, default 50_000_000: length of the POINT (serve pause) state, in clock cycles; must be ≥1.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: raw, asynchronous start push-button, active-high.
- `hit` in 1: right paddle (player R) contact flag from graphics; level, may stay high many cycles.
- `hit2` in 1: left paddle (player L) contact flag; level.
- `miss` in 1: ball-out flag from graphics; level.
- `gra_still` out 1: 1 holds the ball centred and stationary; 0 lets play run.
- `score_r` out 4: player R score.
- `score_l` out 4: player L score.
- `rally` out 8: paddle contacts in the current or last rally; saturates at 255.
- `game_over` out 1: high while in OVER.
- `winner` out 2: 00 none, 01 R, 10 L.

## Operation
- Start path:
  - 2-FF synchronizer, then a counter debouncer. The debounced level flips after the synchronized value has differed from it for `DEBOUNCE_CYCLES` consecutive cycles. Any agreeing sample clears the counter.
  - `start_press` is a one-cycle internal pulse on the debounced 0→1 transition.
- Event detect:
  - `hit`, `hit2` and `miss` are each registered once.
  - Each event is the rising edge, input=1 and registered copy=0. A long-held level counts once.
- `last_hitter` register:
  - Set to R on a `hit` edge and to L on a `hit2` edge. If both occur in the same cycle, R wins.
  - Forced to R on entry to PLAY, because the serve travels toward the left paddle.
- State machine:
  - IDLE, gra_still=1. `start_press` → POINT.
  - POINT, gra_still=1. The serve counter loads 0 on entry and increments each cycle. When it reaches `SERVE_DELAY_CYCLES`-1 → PLAY. POINT therefore lasts exactly `SERVE_DELAY_CYCLES` cycles.
  - PLAY, gra_still=0.
    - On entry, `rally` is cleared.
    - A `hit`/`hit2` edge increments `rally`, saturating at 255.
    - A `miss` edge awards 1 point to `last_hitter`.
    - If the new score equals `WIN_SCORE` → OVER, with `winner` set to that player. Otherwise → POINT.
  - OVER, gra_still=1, game_over=1. `start_press` clears `score_r`, `score_l` and `winner` (`rally` keeps its value), then → POINT.
- Events outside PLAY are ignored:
  - `hit`, `hit2` and `miss` do not change `rally`, `last_hitter` or the scores.
  - The edge registers keep tracking their inputs so that no stale edge fires later.
- `start_press` in POINT or PLAY is ignored.
- A `miss` edge and a `hit` edge in the same PLAY cycle: the miss is scored using `last_hitter` as it stood before that cycle. The rally increment still applies.
- Scores are 4-bit and never exceed `WIN_SCORE`, so there is no wrap.

## Timing
- All outputs are registered.
- Reset values: state IDLE, gra_still=1, score_r=0, score_l=0, rally=0, game_over=0, winner=00, last_hitter=R. Synchronizer, debouncer and edge registers are all 0.
- Asserting `reset` at any time, including mid-rally or mid-POINT, returns every register to its reset value immediately. There is no clock dependency.
- Miss edge sampled at clock edge N (graphics `miss` high, registered copy low):
  - The score increments and the state changes at edge N+1.
  - gra_still is high from edge N+1.
- PLAY entry: gra_still falls at the same edge at which the state becomes PLAY, and `rally` reads 0 from that edge.
- Start latency: with `start` held high from edge 0, `start_press` fires at edge `DEBOUNCE_CYCLES`+2 (2 synchronizer stages, then `DEBOUNCE_CYCLES` samples). The state changes at the following edge.
- Glitches shorter than `DEBOUNCE_CYCLES` cycles produce no press.

## Test plan
Benches use `DEBOUNCE_CYCLES`=4, `SERVE_DELAY_CYCLES`=8, `WIN_SCORE`=3.
- Reset, then start held high from cycle 0 → state POINT from cycle 7, gra_still falls at cycle 15, all scores 0, rally 0.
- In PLAY, `miss` pulsed for 20 cycles with no prior hit → score_r=1 exactly once, gra_still=1 the cycle after the edge, PLAY re-entered 8 cycles later.
- In PLAY, `hit` held for 30 cycles, then `hit2` held for 30 cycles, then `miss` → rally=2, score_l increments, score_r unchanged.
- Start glitch of 3 cycles in IDLE → no state change. Start held in PLAY → ignored, scores unchanged.
- Three L-scoring misses → game_over=1, winner=10, score_l=3. Further `miss`/`hit` edges leave outputs unchanged. Start press → scores 0, winner 00, POINT.
- Reset asserted mid-POINT with score_r=2 → all outputs return to their reset values asynchronously, with gra_still=1 and state IDLE.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// ============================================================================
// pong_game_ctrl
// ----------------------------------------------------------------------------
// Game-flow controller for the two-paddle Pong design. It sits downstream of
// the graphics stage and turns its paddle/ball status flags into game state:
//   - debounces the raw start push-button into a one-cycle press pulse,
//   - detects rising edges of the hit / hit2 / miss level flags,
//   - tracks which paddle touched the ball last,
//   - counts paddle contacts in the current rally (saturating),
//   - awards points, detects the winner and freezes the ball between points.
//
// Parameters
//   WIN_SCORE          score that ends the game (1..15)
//   DEBOUNCE_CYCLES    stable synchronized samples needed to accept a change
//   SERVE_DELAY_CYCLES length of the serve pause in clock cycles (>= 1)
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous reset, active low
//   start      in   raw asynchronous start button, active high
//   hit        in   right paddle (player R) contact flag, level
//   hit2       in   left paddle (player L) contact flag, level
//   miss       in   ball-out flag, level
//   gra_still  out  1 = ball held centred and stationary, 0 = play runs
//   score_r    out  player R score
//   score_l    out  player L score
//   rally      out  paddle contacts in the current/last rally, saturates at 255
//   game_over  out  high while the game is over
//   winner     out  00 none, 01 player R, 10 player L
//
// All outputs are registered.
// ============================================================================
module pong_game_ctrl #(
    parameter int WIN_SCORE          = 9,
    parameter int DEBOUNCE_CYCLES    = 1_000_000,
    parameter int SERVE_DELAY_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       hit,
    input  logic       hit2,
    input  logic       miss,
    output logic       gra_still,
    output logic [3:0] score_r,
    output logic [3:0] score_l,
    output logic [7:0] rally,
    output logic       game_over,
    output logic [1:0] winner
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_POINT = 2'd1;
    localparam logic [1:0] ST_PLAY  = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_R    = 2'b01;
    localparam logic [1:0] WINNER_L    = 2'b10;

    // Counter widths only need to hold 0 .. N-1.
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SV_W = (SERVE_DELAY_CYCLES > 1) ? $clog2(SERVE_DELAY_CYCLES) : 1;

    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SV_W-1:0] SERVE_LAST = SV_W'(SERVE_DELAY_CYCLES - 1);
    localparam logic [3:0]      WIN_PTS    = 4'(WIN_SCORE);

    // Player encoding for last_hitter: 0 = R, 1 = L.
    localparam logic PLAYER_R = 1'b0;
    localparam logic PLAYER_L = 1'b1;

    // ------------------------------------------------------------------------
    // Start button: 2-FF synchronizer, counter debouncer, press pulse
    // ------------------------------------------------------------------------
    logic            start_meta;
    logic            start_sync;
    logic            start_db;      // debounced level
    logic            start_db_q;    // debounced level, one cycle late
    logic            start_press;   // one-cycle pulse on debounced 0->1
    logic [DB_W-1:0] db_cnt;

    // NOTE: every flop in this design, synchronizer included, has an explicit
    // async reset value; nothing relies on power-up contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_meta  <= 1'b0;
            start_sync  <= 1'b0;
            start_db    <= 1'b0;
            start_db_q  <= 1'b0;
            start_press <= 1'b0;
            db_cnt      <= '0;
        end else begin
            // NOTE: sequential state is written with <= so every flop samples
            // the pre-edge value of the others (the sync chain relies on it).
            start_meta <= start;
            start_sync <= start_meta;

            // The debounced level only follows after DEBOUNCE_CYCLES
            // consecutive disagreeing samples; one agreeing sample restarts.
            if (start_sync == start_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                start_db <= start_sync;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end

            start_db_q  <= start_db;
            start_press <= start_db & ~start_db_q;
        end
    end

    // ------------------------------------------------------------------------
    // Event detect: rising edges of the graphics flags, registered.
    // The edge registers keep tracking in every state, so a level that rose
    // while events were being ignored cannot fire later.
    // ------------------------------------------------------------------------
    logic hit_q, hit2_q, miss_q;
    logic hit_ev, hit2_ev, miss_ev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_q   <= 1'b0;
            hit2_q  <= 1'b0;
            miss_q  <= 1'b0;
            hit_ev  <= 1'b0;
            hit2_ev <= 1'b0;
            miss_ev <= 1'b0;
        end else begin
            hit_q   <= hit;
            hit2_q  <= hit2;
            miss_q  <= miss;
            hit_ev  <= hit  & ~hit_q;
            hit2_ev <= hit2 & ~hit2_q;
            miss_ev <= miss & ~miss_q;
        end
    end

    // ------------------------------------------------------------------------
    // Game state machine
    // ------------------------------------------------------------------------
    logic [1:0]      state;
    logic [1:0]      state_next;
    logic [SV_W-1:0] serve_cnt;
    logic            last_hitter;
    logic [3:0]      scorer_score;   // current score of last_hitter
    logic [3:0]      scorer_next;    // that score plus the point on a miss
    logic            win_point;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        scorer_score = (last_hitter == PLAYER_L) ? score_l : score_r;
        scorer_next  = scorer_score + 4'd1;
        win_point    = (scorer_next == WIN_PTS);

        state_next = state;
        case (state)
            ST_IDLE:  if (start_press) state_next = ST_POINT;
            ST_POINT: if (serve_cnt == SERVE_LAST) state_next = ST_PLAY;
            ST_PLAY:  if (miss_ev) state_next = win_point ? ST_OVER : ST_POINT;
            ST_OVER:  if (start_press) state_next = ST_POINT;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            serve_cnt   <= '0;
            last_hitter <= PLAYER_R;
            gra_still   <= 1'b1;
            game_over   <= 1'b0;
            score_r     <= 4'd0;
            score_l     <= 4'd0;
            rally       <= 8'd0;
            winner      <= WINNER_NONE;
        end else begin
            state <= state_next;

            // Outputs are decoded from the next state so they change on the
            // same edge as the state itself.
            gra_still <= (state_next != ST_PLAY);
            game_over <= (state_next == ST_OVER);

            // Held at 0 outside POINT, so it starts from 0 on every entry.
            serve_cnt <= (state == ST_POINT) ? serve_cnt + SV_W'(1) : '0;

            case (state)
                ST_POINT: begin
                    if (state_next == ST_PLAY) begin
                        rally       <= 8'd0;
                        // The serve always travels toward the left paddle.
                        last_hitter <= PLAYER_R;
                    end
                end

                ST_PLAY: begin
                    if ((hit_ev || hit2_ev) && (rally != 8'hFF)) begin
                        rally <= rally + 8'd1;
                    end

                    // R takes priority when both paddles report together.
                    if (hit_ev) begin
                        last_hitter <= PLAYER_R;
                    end else if (hit2_ev) begin
                        last_hitter <= PLAYER_L;
                    end

                    // A simultaneous hit only updates last_hitter for the
                    // next point; this miss is credited to the old value.
                    if (miss_ev) begin
                        if (last_hitter == PLAYER_L) begin
                            score_l <= scorer_next;
                        end else begin
                            score_r <= scorer_next;
                        end
                        if (win_point) begin
                            winner <= (last_hitter == PLAYER_L) ? WINNER_L : WINNER_R;
                        end
                    end
                end

                ST_OVER: begin
                    // rally deliberately keeps the final rally length.
                    if (start_press) begin
                        score_r <= 4'd0;
                        score_l <= 4'd0;
                        winner  <= WINNER_NONE;
                    end
                end

                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// ============================================================================
// tb_pong_game_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for pong_game_ctrl with DEBOUNCE_CYCLES=4,
// SERVE_DELAY_CYCLES=8, WIN_SCORE=3.
//   - hand sequences: reset values, start glitch, minimum-length start pulse,
//     rally saturation, asynchronous reset in the middle of a serve pause
//   - a table of {inputs, repeat count, expected outputs} walking one game
//   - randomized hit/hit2/miss traffic over several games, compared every
//     cycle with a point/rally/serve-timer model of the game rules
// Outputs are compared as one bundle {gra_still, game_over, winner,
// score_r, score_l, rally}.
// ============================================================================
module tb_pong_game_ctrl;

    localparam int DB  = 4;
    localparam int SD  = 8;
    localparam int WIN = 3;

    logic       clk;
    logic       reset;
    logic       start;
    logic       hit;
    logic       hit2;
    logic       miss;
    logic       gra_still;
    logic [3:0] score_r;
    logic [3:0] score_l;
    logic [7:0] rally;
    logic       game_over;
    logic [1:0] winner;

    pong_game_ctrl #(
        .WIN_SCORE          (WIN),
        .DEBOUNCE_CYCLES    (DB),
        .SERVE_DELAY_CYCLES (SD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .hit       (hit),
        .hit2      (hit2),
        .miss      (miss),
        .gra_still (gra_still),
        .score_r   (score_r),
        .score_l   (score_l),
        .rally     (rally),
        .game_over (game_over),
        .winner    (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    function automatic logic [19:0] bundle(input logic g, input logic go,
                                           input logic [1:0] w,
                                           input logic [3:0] r,
                                           input logic [3:0] l,
                                           input logic [7:0] ra);
        return {g, go, w, r, l, ra};
    endfunction

    function automatic logic [19:0] dut_out();
        return {gra_still, game_over, winner, score_r, score_l, rally};
    endfunction

    task automatic check(input string name, input logic [19:0] act,
                         input logic [19:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {still,over,win,r,l,rally}=0x%05h, expected 0x%05h",
                     name, act, exp);
        end
    endtask

    // One clock edge; inputs are driven and outputs sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic s, input logic h, input logic h2,
                          input logic m);
        start = s;
        hit   = h;
        hit2  = h2;
        miss  = m;
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        reset = 1'b1;
    endtask

    logic [19:0] reset_b;

    // ------------------------------------------------------------------------
    // Table-driven game walk
    // ------------------------------------------------------------------------
    typedef struct {
        logic        start;
        logic        hit;
        logic        hit2;
        logic        miss;
        int          reps;
        logic [19:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic s, input logic h, input logic h2,
                                input logic m, input int reps,
                                input logic [19:0] exp);
        vec_t v;
        v.start = s;
        v.hit   = h;
        v.hit2  = h2;
        v.miss  = m;
        v.reps  = reps;
        v.exp   = exp;
        return v;
    endfunction

    // ------------------------------------------------------------------------
    // Reference model: points, rally and serve timer from the game rules.
    // A flag edge seen at one clock edge takes effect at the next one.
    // ------------------------------------------------------------------------
    typedef enum int {M_IDLE, M_POINT, M_PLAY, M_OVER} mphase_t;

    mphase_t m_phase;
    int      m_score[2];     // index 0 = R, 1 = L
    int      m_rally;
    int      m_last;         // 0 = R, 1 = L
    int      m_winner;
    int      m_serve_left;
    bit      pend_hit, pend_hit2, pend_miss;
    bit      prev_hit, prev_hit2, prev_miss;

    task automatic model_edge(input bit h, input bit h2, input bit m,
                              input bit press);
        if (m_phase == M_PLAY) begin
            if (pend_hit || pend_hit2) m_rally = (m_rally < 255) ? m_rally + 1 : 255;
            if (pend_miss) begin
                m_score[m_last] = m_score[m_last] + 1;
                if (m_score[m_last] == WIN) begin
                    m_phase  = M_OVER;
                    m_winner = (m_last == 1) ? 2 : 1;
                end else begin
                    m_phase      = M_POINT;
                    m_serve_left = SD;
                end
            end
            if (pend_hit) m_last = 0;
            else if (pend_hit2) m_last = 1;
        end else if (m_phase == M_POINT) begin
            m_serve_left--;
            if (m_serve_left == 0) begin
                m_phase = M_PLAY;
                m_rally = 0;
                m_last  = 0;
            end
        end else if (press) begin
            if (m_phase == M_OVER) begin
                m_score[0] = 0;
                m_score[1] = 0;
                m_winner   = 0;
            end
            m_phase      = M_POINT;
            m_serve_left = SD;
        end
        pend_hit  = h  && !prev_hit;
        pend_hit2 = h2 && !prev_hit2;
        pend_miss = m  && !prev_miss;
        prev_hit  = h;
        prev_hit2 = h2;
        prev_miss = m;
    endtask

    function automatic logic [19:0] model_out();
        return bundle(m_phase != M_PLAY, m_phase == M_OVER, 2'(m_winner),
                      4'(m_score[0]), 4'(m_score[1]), 8'(m_rally));
    endfunction

    int ov_cnt;
    int games;

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        reset_b = bundle(1'b1, 1'b0, 2'b00, 4'd0, 4'd0, 8'd0);

        // Reset values while reset is held low
        reset_dut();
        reset = 1'b0;
        tick();
        check("reset_values", dut_out(), reset_b);
        reset = 1'b1;

        // 3-cycle start glitch in IDLE: no press, so play never starts
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        start = 1'b0;
        repeat (20) tick();
        check("glitch3_ignored", dut_out(), reset_b);

        // Exactly DEBOUNCE_CYCLES long pulse is accepted; play from edge 15
        start = 1'b1;
        repeat (4) tick();           // edges 0..3
        start = 1'b0;
        repeat (11) tick();          // edges 4..14
        check("pulse4_serving", dut_out(), reset_b);
        tick();                      // edge 15
        check("pulse4_play", dut_out(), bundle(1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 8'd0));

        // Rally saturates at 255
        for (int i = 0; i < 260; i++) begin
            hit = 1'b1;
            tick();
            hit = 1'b0;
            tick();
        end
        tick();
        check("rally_saturate", dut_out(), bundle(1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 8'd255));

        // Two R points, then reset in the middle of the serve pause
        miss = 1'b1;
        repeat (2) tick();
        check("sat_miss_r1", dut_out(), bundle(1'b1, 1'b0, 2'b00, 4'd1, 4'd0, 8'd255));
        miss = 1'b0;
        repeat (8) tick();
        check("replay_r1", dut_out(), bundle(1'b0, 1'b0, 2'b00, 4'd1, 4'd0, 8'd0));
        miss = 1'b1;
        repeat (2) tick();
        check("miss_r2", dut_out(), bundle(1'b1, 1'b0, 2'b00, 4'd2, 4'd0, 8'd0));
        miss = 1'b0;
        repeat (3) tick();
        #2 reset = 1'b0;
        #1;
        check("async_reset_mid_point", dut_out(), reset_b);
        repeat (3) tick();
        reset = 1'b1;
        repeat (20) tick();
        check("idle_after_reset", dut_out(), reset_b);

        // Table-driven walk through one full game and a restart
        tbl.push_back(mk(1, 0, 0, 0,  7, bundle(1, 0, 2'b00, 0, 0, 0)));  // edges 0..6
        tbl.push_back(mk(1, 0, 0, 0,  8, bundle(1, 0, 2'b00, 0, 0, 0)));  // POINT to edge 14
        tbl.push_back(mk(1, 0, 0, 0,  1, bundle(0, 0, 2'b00, 0, 0, 0)));  // PLAY at 15
        tbl.push_back(mk(1, 0, 0, 1,  1, bundle(0, 0, 2'b00, 0, 0, 0)));  // miss edge seen
        tbl.push_back(mk(1, 0, 0, 1,  1, bundle(1, 0, 2'b00, 1, 0, 0)));  // R scores
        tbl.push_back(mk(1, 0, 0, 1,  7, bundle(1, 0, 2'b00, 1, 0, 0)));  // serve pause
        tbl.push_back(mk(1, 0, 0, 1,  1, bundle(0, 0, 2'b00, 1, 0, 0)));  // PLAY again
        tbl.push_back(mk(1, 0, 0, 1, 10, bundle(0, 0, 2'b00, 1, 0, 0)));  // held miss: once
        tbl.push_back(mk(1, 1, 0, 0, 30, bundle(0, 0, 2'b00, 1, 0, 1)));  // held hit: once
        tbl.push_back(mk(1, 0, 1, 0, 30, bundle(0, 0, 2'b00, 1, 0, 2)));  // held hit2: once
        tbl.push_back(mk(1, 0, 0, 1,  2, bundle(1, 0, 2'b00, 1, 1, 2)));  // L scores
        tbl.push_back(mk(1, 0, 0, 0,  7, bundle(1, 0, 2'b00, 1, 1, 2)));  // rally kept
        tbl.push_back(mk(1, 0, 0, 0,  1, bundle(0, 0, 2'b00, 1, 1, 0)));  // rally cleared
        tbl.push_back(mk(0, 0, 0, 0, 10, bundle(0, 0, 2'b00, 1, 1, 0)));  // start released
        tbl.push_back(mk(1, 0, 0, 0, 10, bundle(0, 0, 2'b00, 1, 1, 0)));  // press in PLAY
        tbl.push_back(mk(1, 0, 1, 0,  2, bundle(0, 0, 2'b00, 1, 1, 1)));
        tbl.push_back(mk(1, 0, 0, 1,  2, bundle(1, 0, 2'b00, 1, 2, 1)));
        tbl.push_back(mk(1, 0, 0, 0,  8, bundle(0, 0, 2'b00, 1, 2, 0)));
        tbl.push_back(mk(1, 0, 1, 0,  2, bundle(0, 0, 2'b00, 1, 2, 1)));
        tbl.push_back(mk(1, 0, 0, 1,  2, bundle(1, 1, 2'b10, 1, 3, 1)));  // L wins
        tbl.push_back(mk(1, 0, 0, 0,  2, bundle(1, 1, 2'b10, 1, 3, 1)));
        tbl.push_back(mk(1, 1, 1, 1,  3, bundle(1, 1, 2'b10, 1, 3, 1)));  // events ignored
        tbl.push_back(mk(0, 0, 0, 0, 10, bundle(1, 1, 2'b10, 1, 3, 1)));
        tbl.push_back(mk(1, 0, 0, 0,  7, bundle(1, 1, 2'b10, 1, 3, 1)));  // press pending
        tbl.push_back(mk(1, 0, 0, 0,  1, bundle(1, 0, 2'b00, 0, 0, 1)));  // restart
        tbl.push_back(mk(1, 0, 0, 0,  8, bundle(0, 0, 2'b00, 0, 0, 0)));  // PLAY

        reset_dut();
        foreach (tbl[i]) begin
            set_in(tbl[i].start, tbl[i].hit, tbl[i].hit2, tbl[i].miss);
            repeat (tbl[i].reps) tick();
            check($sformatf("table_row%0d", i), dut_out(), tbl[i].exp);
        end

        // Randomized play against the model, continuing from fresh PLAY
        m_phase      = M_PLAY;
        m_score[0]   = 0;
        m_score[1]   = 0;
        m_rally      = 0;
        m_last       = 0;
        m_winner     = 0;
        m_serve_left = 0;
        pend_hit     = 1'b0;
        pend_hit2    = 1'b0;
        pend_miss    = 1'b0;
        prev_hit     = 1'b0;
        prev_hit2    = 1'b0;
        prev_miss    = 1'b0;
        ov_cnt       = 0;
        games        = 0;

        for (int c = 0; c < 4000 && games < 3; c++) begin
            bit press;
            // In OVER: release start 10 cycles, then hold it; the press takes
            // effect DB+3 edges after the first high sample.
            if (m_phase == M_OVER) begin
                ov_cnt++;
                start = (ov_cnt > 10);
            end else begin
                ov_cnt = 0;
                start  = 1'b1;
            end
            hit   = ($urandom_range(0, 3) == 0);
            hit2  = ($urandom_range(0, 3) == 0);
            miss  = ($urandom_range(0, 11) == 0);
            press = (m_phase == M_OVER) && (ov_cnt == 11 + DB + 3);
            tick();
            if (press) games++;
            model_edge(hit, hit2, miss, press);
            check($sformatf("random_c%0d", c), dut_out(), model_out());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
